// File: rtl/dam_pkg.sv
// Purpose: shared types and constants for the DiffAddMul operation sequencer.
// Latency: n/a (types, constants only).
// Backpressure: n/a.
// Contents: operand width, packet field offsets, path one-hot selects, FSM state enum.
package dam_pkg;

   localparam int W      = 8;        // operand width of i, j, k
   localparam int PCL_W  = 3*W + 1;  // packet width
   localparam int RES_W  = 2*W;      // result width

   // Packet field positions: {i, j, k, op}
   localparam int I_LSB  = 2*W + 1;
   localparam int J_LSB  = W + 1;
   localparam int K_LSB  = 1;
   localparam int OP_BIT = 0;

   // Result path one-hot selects
   localparam logic [2:0] SEL_NEG = 3'b001;
   localparam logic [2:0] SEL_MUL = 3'b010;
   localparam logic [2:0] SEL_ADD = 3'b100;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SUB  = 3'd1,
      ADD  = 3'd2,
      MUL  = 3'd3,
      OUT  = 3'd4
   } state_t;

endpackage

// File: rtl/dam_seq_mul.sv
// Purpose: iterative W x W unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
// Latency: W cycles after the start edge; o_done is high in the last cycle, with o_p already final.
// Backpressure: none; the caller must sample o_p on the cycle o_done is high.
// Ports: i_clk, i_rst_n (async active-low), i_start (loads operands), i_a/i_b (operands),
//        o_done (final-bit cycle), o_p (accumulator including the current partial product).
module dam_seq_mul #(
   parameter int W = 8
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_start,
   input  logic [W-1:0]   i_a,
   input  logic [W-1:0]   i_b,
   output logic           o_done,
   output logic [2*W-1:0] o_p
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   logic           r_run;
   logic [CW-1:0]  r_cnt;
   logic [2*W-1:0] r_a;      // multiplicand, pre-shifted to the current bit weight
   logic [W-1:0]   r_b;      // multiplier, shifted right so bit 0 is the current bit
   logic [2*W-1:0] r_acc;
   logic [2*W-1:0] w_addend;

   assign w_addend = r_b[0] ? r_a : '0;
   // Exposing acc + current addend lets the caller capture the product on the
   // done cycle itself instead of one cycle later.
   assign o_p      = r_acc + w_addend;
   assign o_done   = r_run && (r_cnt == '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_run <= 1'b0;
         r_cnt <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_acc <= '0;
      end else if (i_start) begin
         r_run <= 1'b1;
         r_cnt <= CW'(W-1);
         r_a   <= {{W{1'b0}}, i_a};
         r_b   <= i_b;
         r_acc <= '0;
      end else if (r_run) begin
         r_acc <= o_p;
         r_a   <= r_a << 1;
         r_b   <= r_b >> 1;
         if (r_cnt == '0) begin
            r_run <= 1'b0;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/dam_op_sequencer.sv
// Purpose: DiffAddMul controller: d = i - j, then zero (d < 0), d + k (op=0) or d * k (op=1).
// Latency: accept edge to o_out_valid: negative 2, add 3, mul W+2 cycles; one packet in flight.
// Backpressure: o_in_ready only in IDLE; result held in OUT until i_out_ready, no out->in comb path.
// Ports: i_clk, i_reset_n (async active-low); input handshake i_in_valid/o_in_ready/i_in_pcl {i,j,k,op};
//        output handshake o_out_valid/i_out_ready with o_out_data (2W, zero-extended) and
//        o_out_sel (001 neg, 010 mul, 100 add); o_busy high outside IDLE.
module dam_op_sequencer
   import dam_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [PCL_W-1:0] i_in_pcl,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [RES_W-1:0] o_out_data,
   output logic [2:0]       o_out_sel,
   output logic             o_busy
);

   state_t           r_state;
   state_t           w_state_nxt;

   logic [W-1:0]     r_i;
   logic [W-1:0]     r_j;
   logic [W-1:0]     r_k;
   logic             r_op;
   logic [W:0]       r_diff;     // bit W is the borrow, i.e. i < j
   logic             r_sub_ph;   // 0: first SUB cycle (register diff), 1: route on registered diff
   logic [RES_W-1:0] r_out_data;
   logic [2:0]       r_out_sel;

   logic             w_accept;
   logic             w_route;
   logic             w_neg;
   logic             w_mul_start;
   logic             w_mul_done;
   logic [RES_W-1:0] w_mul_p;
   logic [W:0]       w_sum;

   assign w_accept    = (r_state == IDLE) && i_in_valid;
   assign w_route     = (r_state == SUB) && r_sub_ph;
   assign w_neg       = r_diff[W];
   assign w_mul_start = w_route && !w_neg && r_op;
   assign w_sum       = {1'b0, r_diff[W-1:0]} + {1'b0, r_k};

   dam_seq_mul #(.W(W)) u_mul (
      .i_clk   (i_clk),
      .i_rst_n (i_reset_n),
      .i_start (w_mul_start),
      .i_a     (r_diff[W-1:0]),
      .i_b     (r_k),
      .o_done  (w_mul_done),
      .o_p     (w_mul_p)
   );

   // State register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (i_in_valid) w_state_nxt = SUB;
         SUB: begin
            if (r_sub_ph) begin
               if (w_neg)     w_state_nxt = OUT;
               else if (r_op) w_state_nxt = MUL;
               else           w_state_nxt = ADD;
            end
         end
         ADD: w_state_nxt = OUT;
         MUL: if (w_mul_done) w_state_nxt = OUT;
         OUT: if (i_out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      o_busy      = 1'b1;
      case (r_state)
         IDLE: begin
            o_in_ready = 1'b1;
            o_busy     = 1'b0;
         end
         OUT:     o_out_valid = 1'b1;
         default: ;
      endcase
   end

   assign o_out_data = r_out_data;
   assign o_out_sel  = r_out_sel;

   // Datapath: packet capture, difference, result registers (held outside OUT)
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_i        <= '0;
         r_j        <= '0;
         r_k        <= '0;
         r_op       <= 1'b0;
         r_diff     <= '0;
         r_sub_ph   <= 1'b0;
         r_out_data <= '0;
         r_out_sel  <= '0;
      end else begin
         if (w_accept) begin
            r_i      <= i_in_pcl[I_LSB +: W];
            r_j      <= i_in_pcl[J_LSB +: W];
            r_k      <= i_in_pcl[K_LSB +: W];
            r_op     <= i_in_pcl[OP_BIT];
            r_sub_ph <= 1'b0;
         end
         if ((r_state == SUB) && !r_sub_ph) begin
            r_diff   <= {1'b0, r_i} - {1'b0, r_j};
            r_sub_ph <= 1'b1;
         end
         if (w_route && w_neg) begin
            r_out_data <= '0;
            r_out_sel  <= SEL_NEG;
         end
         if (r_state == ADD) begin
            r_out_data <= {{(W-1){1'b0}}, w_sum};
            r_out_sel  <= SEL_ADD;
         end
         if ((r_state == MUL) && w_mul_done) begin
            r_out_data <= w_mul_p;
            r_out_sel  <= SEL_MUL;
         end
      end
   end

endmodule

// File: tb/tb_dam_op_sequencer.sv
// Purpose: directed self-checking bench for dam_op_sequencer with hand-computed results.
// Latency: measured per packet from the accepting edge to o_out_valid.
// Backpressure: exercises a held OUT state with in_valid asserted throughout.
module tb_dam_op_sequencer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [24:0] in_pcl;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [2:0]  out_sel;
   logic        busy;

   int n_checks;
   int n_fail;

   dam_op_sequencer dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_pcl    (in_pcl),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_data  (out_data),
      .o_out_sel   (out_sel),
      .o_busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_pkt(input int i, input int j, input int k, input bit op);
      logic [7:0] vi, vj, vk;
      vi = i[7:0];
      vj = j[7:0];
      vk = k[7:0];
      in_pcl = {vi, vj, vk, op};
   endtask

   // Waits from the negedge after the accepting edge until out_valid, bounded.
   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
   endtask

   // Full packet with out_ready high: accept, latency, result, handshake back to IDLE.
   task automatic run_pkt(input string tag, input int i, input int j, input int k, input bit op,
                          input int exp_lat, input logic [15:0] exp_d, input logic [2:0] exp_s);
      int lat;
      @(negedge clk);
      set_pkt(i, j, k, op);
      in_valid = 1'b1;
      chk({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_busy"}, busy, 1);
      wait_out(lat);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_data"}, out_data, exp_d);
      chk({tag, "_sel"}, out_sel, exp_s);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_done_idle"}, {out_valid, in_ready}, 2'b01);
   endtask

   initial begin
      int lat;
      bit seen;
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_pcl    = '0;
      out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sel", out_sel, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Main paths and arithmetic boundaries
      run_pkt("add_20_5_3", 20, 5, 3, 1'b0, 3, 16'h0012, 3'b100);
      run_pkt("mul_20_5_3", 20, 5, 3, 1'b1, 10, 16'h002D, 3'b010);
      run_pkt("neg_5_20_mul", 5, 20, 7, 1'b1, 2, 16'h0000, 3'b001);
      run_pkt("neg_0_1_add", 0, 1, 9, 1'b0, 2, 16'h0000, 3'b001);
      run_pkt("mul_max", 255, 0, 255, 1'b1, 10, 16'hFE01, 3'b010);
      run_pkt("add_max", 255, 0, 255, 1'b0, 3, 16'h01FE, 3'b100);
      run_pkt("mul_eq", 9, 9, 77, 1'b1, 10, 16'h0000, 3'b010);
      run_pkt("add_eq", 9, 9, 77, 1'b0, 3, 16'h004D, 3'b100);

      // Backpressure: result held while out_ready low, second packet waiting on in_valid
      @(negedge clk);
      out_ready = 1'b0;
      set_pkt(20, 5, 3, 1'b0);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      set_pkt(7, 3, 2, 1'b1);   // next packet, 4 * 2 = 8
      wait_out(lat);
      chk("stall_lat", lat, 3);
      for (int c = 0; c < 5; c++) begin
         chk("stall_hold", {out_valid, in_ready, out_sel, out_data},
             {1'b1, 1'b0, 3'b100, 16'h0012});
         @(posedge clk);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("stall_release", {out_valid, in_ready, busy}, 3'b010);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("stall_next_accept", busy, 1);
      wait_out(lat);
      chk("stall_next_lat", lat, 10);
      chk("stall_next_data", out_data, 16'h0008);
      chk("stall_next_sel", out_sel, 3'b010);
      @(posedge clk);
      @(negedge clk);

      // Async reset 4 cycles into MUL
      set_pkt(20, 5, 3, 1'b1);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("abort_busy_before", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_async", {in_ready, out_valid, busy, out_sel, out_data},
          {1'b1, 1'b0, 1'b0, 3'b000, 16'h0000});
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("abort_no_out", seen, 0);
      run_pkt("after_abort_add", 30, 10, 5, 1'b0, 3, 16'h0019, 3'b100);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
